// File: rtl/slideshow_sequencer.sv
// slideshow_sequencer: maps letterboxed display coordinates to an upscaled
// image-memory address and drives a frame-synchronous fade/swap/fade
// transition between stored images on button or auto-advance requests.
module slideshow_sequencer #(
  parameter int unsigned N_IMG            = 4,
  parameter int unsigned IMG_W            = 160,
  parameter int unsigned IMG_H            = 90,
  parameter int unsigned SCALE_SH         = 2,
  parameter int unsigned HOLD_FRAMES      = 300,
  parameter int unsigned FADE_STEP_FRAMES = 2,
  parameter int unsigned ADDR_W           = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pix_stb,
  input  logic                     i_animate,
  input  logic                     i_active,
  input  logic [9:0]               i_x,
  input  logic [8:0]               i_y,
  input  logic                     i_next,
  input  logic                     i_prev,
  input  logic                     i_auto_en,
  output logic [ADDR_W-1:0]        o_addr,
  output logic                     o_addr_valid,
  output logic [3:0]               o_level,
  output logic [$clog2(N_IMG)-1:0] o_img_idx,
  output logic                     o_busy
);

  localparam int unsigned IDX_W  = $clog2(N_IMG);
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned STEP_W = $clog2(FADE_STEP_FRAMES + 1);
  localparam int unsigned IMG_SZ = IMG_W * IMG_H;

  typedef enum logic [1:0] {SHOW, FADE_OUT, SWAP, FADE_IN} state_t;
  typedef enum logic [1:0] {P_NONE, P_NEXT, P_PREV} pend_t;

  state_t              state;
  pend_t               pending;
  logic [IDX_W-1:0]    target;
  logic [IDX_W-1:0]    idx_inc;
  logic [IDX_W-1:0]    idx_dec;
  logic [ADDR_W-1:0]   base;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                hold_wrap;
  logic                auto_fire;
  logic                step_last;

  // Neighbouring image indices with wrap-around, and per-frame counter terminal flags
  always_comb begin
    idx_inc   = (o_img_idx == IDX_W'(N_IMG - 1)) ? '0 : o_img_idx + 1'b1;
    idx_dec   = (o_img_idx == '0) ? IDX_W'(N_IMG - 1) : o_img_idx - 1'b1;
    hold_wrap = (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
    auto_fire = i_auto_en && i_animate && hold_wrap;
    step_last = (step_cnt == STEP_W'(FADE_STEP_FRAMES - 1));
  end

  // Transition FSM: request capture, auto-advance, fade stepping and image swap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= SHOW;
      pending   <= P_NONE;
      target    <= '0;
      o_img_idx <= '0;
      base      <= '0;
      o_level   <= '1;
      o_busy    <= 1'b0;
      hold_cnt  <= '0;
      step_cnt  <= '0;
    end else begin
      case (state)
        SHOW: begin
          if (!i_auto_en)
            hold_cnt <= '0;
          else if (i_animate)
            hold_cnt <= hold_wrap ? '0 : hold_cnt + 1'b1;
          // A request landing on the starting animate is dropped: the block is busy from then on
          if (i_animate && pending != P_NONE) begin
            target   <= (pending == P_NEXT) ? idx_inc : idx_dec;
            pending  <= P_NONE;
            step_cnt <= '0;
            hold_cnt <= '0;
            o_busy   <= 1'b1;
            state    <= FADE_OUT;
          end else if (i_next && !i_prev) begin
            pending <= P_NEXT;
          end else if (i_prev && !i_next) begin
            pending <= P_PREV;
          end else if (auto_fire && pending == P_NONE) begin
            pending <= P_NEXT;
          end
        end
        FADE_OUT: begin
          hold_cnt <= '0;
          if (i_animate) begin
            if (step_last) begin
              step_cnt <= '0;
              o_level  <= o_level - 1'b1;
              if (o_level == 4'd1) state <= SWAP;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        SWAP: begin
          hold_cnt  <= '0;
          o_img_idx <= target;
          base      <= ADDR_W'(32'(target) * IMG_SZ);
          step_cnt  <= '0;
          state     <= FADE_IN;
        end
        FADE_IN: begin
          hold_cnt <= '0;
          if (i_animate) begin
            if (step_last) begin
              step_cnt <= '0;
              o_level  <= o_level + 1'b1;
              if (o_level == 4'd14) begin
                state  <= SHOW;
                o_busy <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= SHOW;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Scaled image-memory address, registered on each pixel strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_addr       <= '0;
      o_addr_valid <= 1'b0;
    end else if (i_pix_stb) begin
      o_addr       <= base + ADDR_W'(32'(i_y >> SCALE_SH) * IMG_W)
                           + ADDR_W'(32'(i_x >> SCALE_SH));
      o_addr_valid <= i_active;
    end
  end

endmodule
